// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: FSM state
// encodings, opcode and funct values, alu_op codes and ALU F encodings.
// No ports; imported by the control unit, the ALU decoder and the ALU bench.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_DFLT  = 2'b11;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational ALU decoder: maps the main FSM's alu_op and the
// instruction funct field to the ALU function select F.
// Ports:
//   alu_op      in  2  00 add, 01 sub, 10 decode funct, 11 default
//   funct       in  6  instr[5:0]
//   alu_control out 3  ALU F
module mc_alu_decoder
  import mc_ctrl_pkg::*;
#(
  parameter logic [2:0] DEFAULT_ALU_CTRL = 3'b010
) (
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = DEFAULT_ALU_CTRL;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          default: alu_control = DEFAULT_ALU_CTRL;
        endcase
      end
      default: alu_control = DEFAULT_ALU_CTRL;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle MIPS control unit: Moore main FSM plus ALU decoder.
// Drives all datapath mux selects and write enables.
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   opcode, funct       instruction fields from the IR
//   zero                ALU zero flag, resolves beq
//   alu_control         ALU F select
//   alu_src_a/b, pc_src, iord, reg_dst, mem_to_reg   datapath selects
//   pc_en, mem_write, ir_write, reg_write            strobes (0 in reset)
//   state               current FSM state
//
// state      | meaning
// FETCH    0 | read instr at PC into IR, PC <= PC+4
// DECODE   1 | read regs, precompute branch target
// MEMADR   2 | lw/sw address = regA + signimm
// MEMREAD  3 | read data memory at ALUOut
// MEMWB    4 | write memory data to rt
// MEMWRITE 5 | write regB to memory at ALUOut
// EXECUTE  6 | R-type ALU operation
// ALUWB    7 | write ALUOut to rd
// BRANCH   8 | beq compare, PC <= target if zero
// ADDIEXEC 9 | regA + signimm
// ADDIWB  10 | write ALUOut to rt
// JUMP    11 | PC <= jump target
// 12-15      | illegal, back to FETCH with strobes off
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter logic [2:0] DEFAULT_ALU_CTRL = 3'b010
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [2:0] alu_control,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic [3:0] state
);

  state_t     state_q, state_d;
  logic [1:0] alu_op;
  logic       pc_write, branch;
  logic       mem_write_ungated, ir_write_ungated, reg_write_ungated;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d           = S_FETCH;
    alu_op            = ALUOP_ADD;
    alu_src_a         = 1'b0;
    alu_src_b         = 2'b00;
    pc_src            = 2'b00;
    iord              = 1'b0;
    reg_dst           = 1'b0;
    mem_to_reg        = 1'b0;
    pc_write          = 1'b0;
    branch            = 1'b0;
    mem_write_ungated = 1'b0;
    ir_write_ungated  = 1'b0;
    reg_write_ungated = 1'b0;
    case (state_q)
      S_FETCH: begin
        state_d          = S_DECODE;
        alu_src_b        = 2'b01;
        ir_write_ungated = 1'b1;
        pc_write         = 1'b1;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        // IR is only loaded in FETCH, so opcode is still the lw/sw seen in DECODE
        state_d   = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMREAD: begin
        state_d = S_MEMWB;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg        = 1'b1;
        reg_write_ungated = 1'b1;
      end
      S_MEMWRITE: begin
        iord              = 1'b1;
        mem_write_ungated = 1'b1;
      end
      S_EXECUTE: begin
        state_d   = S_ALUWB;
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_dst           = 1'b1;
        reg_write_ungated = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = 2'b01;
        branch    = 1'b1;
      end
      S_ADDIEXEC: begin
        state_d   = S_ADDIWB;
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDIWB: begin
        reg_write_ungated = 1'b1;
      end
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Strobes are masked by rst_n so nothing writes while reset is held,
  // even though the FETCH decode would otherwise raise ir_write/pc_write.
  assign pc_en     = rst_n & (pc_write | (branch & zero));
  assign mem_write = rst_n & mem_write_ungated;
  assign ir_write  = rst_n & ir_write_ungated;
  assign reg_write = rst_n & reg_write_ungated;
  assign state     = state_q;

  mc_alu_decoder #(
    .DEFAULT_ALU_CTRL(DEFAULT_ALU_CTRL)
  ) u_alu_decoder (
    .alu_op     (alu_op),
    .funct      (funct),
    .alu_control(alu_control)
  );

endmodule
